// File: rtl/te_block_expander.sv
// ---------------------------------------------------------------------------
// te_block_expander
//
// Reads instruction-trace ingress blocks (iretire/ilastsize/itype/iaddr/
// cause/tval/priv), buffers them, and reconstructs one record per retired
// instruction by walking each block from its iaddr. The size of each step is
// taken from a same-cycle instruction-size lookup. Exception/interrupt blocks
// end with an extra trap record.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   blk_*_i / blk_ready_o    input block stream (buffered in a small FIFO)
//   fetch_addr_o             size-lookup address (always the current pc)
//   fetch_compressed_i       lookup reply: instruction at fetch_addr_o is 16-bit
//   ret_*                    output record stream
//   err_o / err_code_o       one-cycle error pulse: 1 last-size mismatch,
//                            2 overrun, 3 empty non-trap block
//   dbg_state_o              current FSM state (0 IDLE, 1 WALK, 2 TRAP)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and all payload stable until it sees
// ready; ready never depends combinationally on the other side's valid.
// ---------------------------------------------------------------------------
module te_block_expander #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned IRETIRE_LEN = 32,
    parameter int unsigned ITYPE_LEN   = 3,
    parameter int unsigned PRIV_LEN    = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // block ingress
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [IRETIRE_LEN-1:0] iretire_i,
    input  logic                   ilastsize_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [XLEN-1:0]        cause_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic [XLEN-1:0]        iaddr_i,
    // size lookup
    output logic [XLEN-1:0]        fetch_addr_o,
    input  logic                   fetch_compressed_i,
    // record egress
    output logic                   ret_valid_o,
    input  logic                   ret_ready_i,
    output logic [XLEN-1:0]        ret_pc_o,
    output logic                   ret_compressed_o,
    output logic                   ret_last_o,
    output logic [ITYPE_LEN-1:0]   ret_itype_o,
    output logic [PRIV_LEN-1:0]    ret_priv_o,
    output logic                   ret_trap_o,
    output logic [XLEN-1:0]        ret_cause_o,
    output logic [XLEN-1:0]        ret_tval_o,
    // errors / debug
    output logic                   err_o,
    output logic [1:0]             err_code_o,
    output logic [1:0]             dbg_state_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_TRAP = 2'd2
    } state_e;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } blk_t;

    // ------------------------------------------------------------------
    // Input block FIFO
    // ------------------------------------------------------------------
    blk_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    blk_t             blk_in;
    blk_t             head;

    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // Ready comes from the registered fill level only, so a same-cycle pop
    // never opens an extra slot for the producer.
    assign blk_ready_o = !full;
    assign push        = blk_valid_i && !full;
    assign head        = mem[rd_ptr_q];

    always_comb begin
        blk_in           = '0;
        blk_in.iretire   = iretire_i;
        blk_in.ilastsize = ilastsize_i;
        blk_in.itype     = itype_i;
        blk_in.cause     = cause_i;
        blk_in.tval      = tval_i;
        blk_in.priv      = priv_i;
        blk_in.iaddr     = iaddr_i;
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= blk_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Walker
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [XLEN-1:0]        pc_q;
    logic [IRETIRE_LEN-1:0] rem_q;

    logic                   head_trap;
    logic [IRETIRE_LEN-1:0] step_hw;     // current instruction size in halfwords
    logic [IRETIRE_LEN-1:0] last_hw;     // size the block claims for its last instruction
    logic                   walk_last;
    logic                   ret_hs;

    assign head_trap = (head.itype == ITYPE_LEN'(1)) || (head.itype == ITYPE_LEN'(2));
    assign step_hw   = fetch_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign last_hw   = head.ilastsize ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1);
    assign walk_last = (rem_q <= step_hw);
    assign ret_hs    = ret_valid_o && ret_ready_i;

    assign fetch_addr_o = pc_q;
    assign dbg_state_o  = state_q;

    // Record fields are driven only in WALK/TRAP so they read as zero
    // whenever ret_valid_o is low.
    always_comb begin
        ret_valid_o      = 1'b0;
        ret_pc_o         = '0;
        ret_compressed_o = 1'b0;
        ret_last_o       = 1'b0;
        ret_itype_o      = '0;
        ret_priv_o       = '0;
        ret_trap_o       = 1'b0;
        ret_cause_o      = '0;
        ret_tval_o       = '0;
        err_o            = 1'b0;
        err_code_o       = 2'd0;
        pop              = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // An empty non-trap block carries nothing to emit: drop it.
                if (!empty && (head.iretire == '0) && !head_trap) begin
                    pop        = 1'b1;
                    err_o      = 1'b1;
                    err_code_o = 2'd3;
                end
            end
            S_WALK: begin
                ret_valid_o      = 1'b1;
                ret_pc_o         = pc_q;
                ret_compressed_o = fetch_compressed_i;
                ret_last_o       = walk_last;
                ret_itype_o      = walk_last ? head.itype : '0;
                ret_priv_o       = head.priv;
                if (ret_hs && walk_last) begin
                    // Overrun wins over the size mismatch: a 4-byte step with
                    // one halfword left cannot be the block's last instruction.
                    if (rem_q < step_hw) begin
                        err_o      = 1'b1;
                        err_code_o = 2'd2;
                    end else if (step_hw != last_hw) begin
                        err_o      = 1'b1;
                        err_code_o = 2'd1;
                    end
                    pop = !head_trap;
                end
            end
            S_TRAP: begin
                ret_valid_o = 1'b1;
                ret_trap_o  = 1'b1;
                ret_pc_o    = head.iaddr;
                ret_last_o  = 1'b1;
                ret_itype_o = head.itype;
                ret_priv_o  = head.priv;
                ret_cause_o = head.cause;
                ret_tval_o  = head.tval;
                pop         = ret_ready_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        if (head.iretire != '0) begin
                            pc_q    <= head.iaddr;
                            rem_q   <= head.iretire;
                            state_q <= S_WALK;
                        end else if (head_trap) begin
                            state_q <= S_TRAP;
                        end
                    end
                end
                S_WALK: begin
                    if (ret_hs) begin
                        if (walk_last) begin
                            state_q <= head_trap ? S_TRAP : S_IDLE;
                        end else begin
                            // rem_q > step_hw here, so the subtract cannot wrap.
                            pc_q  <= pc_q + (fetch_compressed_i ? XLEN'(2) : XLEN'(4));
                            rem_q <= rem_q - step_hw;
                        end
                    end
                end
                S_TRAP: begin
                    if (ret_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_te_block_expander.sv
// ---------------------------------------------------------------------------
// tb_te_block_expander
//
// Directed scenarios followed by randomized blocks. Expected records and
// error pulses are produced by a behavioural block-walk model and queued;
// a negedge monitor compares every accepted record and every error pulse,
// checks that stalled records hold, and that idle record fields are zero.
// ---------------------------------------------------------------------------
module tb_te_block_expander;

    localparam int XLEN = 64;
    localparam int RW   = XLEN + 1 + 1 + 3 + 2 + 1 + XLEN + XLEN;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic            blk_valid = 1'b0;
    logic            blk_ready;
    logic [31:0]     iretire   = '0;
    logic            ilastsize = 1'b0;
    logic [2:0]      itype     = '0;
    logic [XLEN-1:0] cause     = '0;
    logic [XLEN-1:0] tval      = '0;
    logic [1:0]      priv      = '0;
    logic [XLEN-1:0] iaddr     = '0;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_compressed;
    logic            ret_valid;
    logic            ret_ready = 1'b1;
    logic [XLEN-1:0] ret_pc;
    logic            ret_comp;
    logic            ret_last;
    logic [2:0]      ret_itype;
    logic [1:0]      ret_priv;
    logic            ret_trap;
    logic [XLEN-1:0] ret_cause;
    logic [XLEN-1:0] ret_tval;
    logic            err;
    logic [1:0]      err_code;
    logic [1:0]      dbg_state;

    te_block_expander dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .blk_valid_i        (blk_valid),
        .blk_ready_o        (blk_ready),
        .iretire_i          (iretire),
        .ilastsize_i        (ilastsize),
        .itype_i            (itype),
        .cause_i            (cause),
        .tval_i             (tval),
        .priv_i             (priv),
        .iaddr_i            (iaddr),
        .fetch_addr_o       (fetch_addr),
        .fetch_compressed_i (fetch_compressed),
        .ret_valid_o        (ret_valid),
        .ret_ready_i        (ret_ready),
        .ret_pc_o           (ret_pc),
        .ret_compressed_o   (ret_comp),
        .ret_last_o         (ret_last),
        .ret_itype_o        (ret_itype),
        .ret_priv_o         (ret_priv),
        .ret_trap_o         (ret_trap),
        .ret_cause_o        (ret_cause),
        .ret_tval_o         (ret_tval),
        .err_o              (err),
        .err_code_o         (err_code),
        .dbg_state_o        (dbg_state)
    );

    // ---------------- size lookup memory model ----------------
    // mode 0: address hash, 1: all 4-byte, 2: all 2-byte, 3: only 0x1004 is 2-byte
    int lk_mode = 1;

    function automatic logic lookup(input logic [XLEN-1:0] a, input int mode);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (a == 64'h1004);
            default: return a[2] ^ a[5] ^ a[8];
        endcase
    endfunction

    assign fetch_compressed = lookup(fetch_addr, lk_mode);

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    logic [1:0]    err_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the block in halfwords using the lookup memory.
    task automatic model_block(input logic [31:0] ir, input logic ils, input logic [2:0] ity,
                               input logic [XLEN-1:0] ca, input logic [XLEN-1:0] tv,
                               input logic [1:0] pr, input logic [XLEN-1:0] ia);
        logic [XLEN-1:0] pc;
        longint          rem;
        longint          sz;
        logic            c;
        logic            lst;
        bit              is_trap;
        pc      = ia;
        rem     = longint'(ir);
        is_trap = (ity == 3'd1) || (ity == 3'd2);
        if (rem == 0 && !is_trap) begin
            err_q.push_back(2'd3);
            return;
        end
        while (rem > 0) begin
            c   = lookup(pc, lk_mode);
            sz  = c ? 1 : 2;
            lst = (rem <= sz);
            exp_q.push_back({pc, c, lst, (lst ? ity : 3'd0), pr, 1'b0, 64'd0, 64'd0});
            if (lst) begin
                if (rem < sz) err_q.push_back(2'd2);
                else if (sz != (ils ? 2 : 1)) err_q.push_back(2'd1);
                rem = 0;
            end else begin
                pc  = pc + XLEN'(2 * sz);
                rem = rem - sz;
            end
        end
        if (is_trap) exp_q.push_back({ia, 1'b0, 1'b1, ity, pr, 1'b1, ca, tv});
    endtask

    // ---------------- monitor ----------------
    logic [RW-1:0] obs_rec;
    logic [RW-1:0] prev_rec   = '0;
    bit            prev_stall = 1'b0;
    bit            mon_en     = 1'b0;

    assign obs_rec = {ret_pc, ret_comp, ret_last, ret_itype, ret_priv, ret_trap, ret_cause, ret_tval};

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (prev_stall && ret_valid) check("stall_hold", obs_rec, prev_rec);
            if (ret_valid && ret_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL record_extra observed=%0h expected=none", obs_rec);
                end else begin
                    check("record", obs_rec, exp_q.pop_front());
                end
            end
            if (!ret_valid) check("idle_fields_zero", obs_rec, '0);
            if (err) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL err_extra observed=%0d expected=none", err_code);
                end else begin
                    check("err_code", RW'(err_code), RW'(err_q.pop_front()));
                end
            end else begin
                check("err_code_quiet", RW'(err_code), '0);
            end
            prev_stall = ret_valid && !ret_ready;
            prev_rec   = obs_rec;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- random ready driver ----------------
    bit rnd_rdy = 1'b0;
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            ret_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_blk(input logic [31:0] ir, input logic ils, input logic [2:0] ity,
                            input logic [XLEN-1:0] ca, input logic [XLEN-1:0] tv,
                            input logic [1:0] pr, input logic [XLEN-1:0] ia);
        int waited = 0;
        blk_valid = 1'b1;
        iretire   = ir;
        ilastsize = ils;
        itype     = ity;
        cause     = ca;
        tval      = tv;
        priv      = pr;
        iaddr     = ia;
        // blk_ready comes from a register, so its value after the edge holds
        // for the following edge.
        while (!blk_ready && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (blk_ready) begin
            model_block(ir, ils, ity, ca, tv, pr, ia);
            @(posedge clk);
            #1;
        end else begin
            check("push_timeout", RW'(waited), '0);
        end
        blk_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || ret_valid) && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check(tag, RW'(exp_q.size() + err_q.size()), '0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_ready", RW'(blk_ready), RW'(1));
        check("rst_ret_valid", RW'(ret_valid), '0);
        check("rst_ret_fields", obs_rec, '0);
        check("rst_err", RW'({err, err_code}), '0);
        check("rst_fetch_addr", RW'(fetch_addr), '0);
        check("rst_state", RW'(dbg_state), '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Plain walk with a mixed-size lookup.
        lk_mode = 3;
        push_blk(32'd6, 1'b1, 3'd0, 64'd0, 64'd0, 2'd3, 64'h1000);
        drain("walk_mixed_done");

        // Zero-length exception block: trap record only.
        lk_mode = 1;
        push_blk(32'd0, 1'b0, 3'd1, 64'd2, 64'hdead, 2'd1, 64'h2000);
        drain("trap_only_done");
        check("trap_only_fifo_empty", RW'(blk_ready), RW'(1));
        check("trap_only_idle", RW'(dbg_state), '0);

        // Interrupt after one 4-byte instruction.
        push_blk(32'd2, 1'b1, 3'd2, 64'h8000000000000007, 64'h0, 2'd0, 64'h4000);
        drain("walk_then_trap_done");

        // Error codes: overrun, last-size mismatch, empty non-trap block.
        push_blk(32'd3, 1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 64'h5000);
        push_blk(32'd2, 1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 64'h6000);
        push_blk(32'd0, 1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 64'h7000);
        drain("errors_done");

        // Back-pressure: FIFO fills at four blocks, records hold while stalled.
        ret_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_blk(32'd2, 1'b1, 3'd0, 64'd0, 64'd0, 2'(i), 64'h8000 + 64'(i * 16));
        check("full_blk_ready_low", RW'(blk_ready), '0);
        fork
            begin
                for (int i = 4; i < 6; i++)
                    push_blk(32'd2, 1'b1, 3'd0, 64'd0, 64'd0, 2'(i), 64'h8000 + 64'(i * 16));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                ret_ready = 1'b1;
            end
        join
        drain("backpressure_done");

        // pc wraps modulo 2^XLEN.
        lk_mode = 2;
        push_blk(32'd2, 1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 64'hFFFFFFFFFFFFFFFE);
        drain("wrap_done");

        // Randomized blocks with random consumer stalls.
        lk_mode = 0;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            push_blk($urandom_range(0, 9), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                     {$urandom, $urandom} & ~64'h1);
        end
        drain("random_done");
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        ret_ready = 1'b1;

        // Reset in the middle of a long walk.
        lk_mode = 2;
        push_blk(32'd20, 1'b0, 3'd1, 64'd5, 64'd6, 2'd1, 64'h9000);
        begin
            int w = 0;
            while (!ret_valid && w < 20) begin
                @(posedge clk);
                #1;
                w++;
            end
            check("midwalk_started", RW'(ret_valid), RW'(1));
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ret_valid", RW'(ret_valid), '0);
        check("midrst_blk_ready", RW'(blk_ready), RW'(1));
        check("midrst_fetch_addr", RW'(fetch_addr), '0);
        check("midrst_state", RW'(dbg_state), '0);
        exp_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", RW'({ret_valid, err}), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
